// File: rtl/irq_src_pkg.sv
// Shared definitions for the peripheral interrupt source: register map,
// coalescing FSM states, reset constants and bus byte-enable helpers.
package irq_src_pkg;

  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_ENABLE  = 3'd1;
  localparam logic [2:0] REG_CLEAR   = 3'd2;
  localparam logic [2:0] REG_THRESH  = 3'd3;
  localparam logic [2:0] REG_TIMEOUT = 3'd4;
  localparam logic [2:0] REG_EVT_CNT = 3'd5;
  localparam logic [2:0] REG_RAW     = 3'd6;

  localparam logic [7:0]  THRESH_RST  = 8'd1;
  localparam int unsigned TIMEOUT_RST = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FIRE    = 2'd2,
    ST_GAP     = 2'd3
  } coal_state_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  function automatic logic [31:0] wstrb_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] m;
    m = strb_mask(strb);
    return (old_val & ~m) | (wdata & m);
  endfunction

endpackage

// File: rtl/irq_event_src_if.sv
// Peripheral bus seen by the interrupt source: one-cycle strobes in,
// one-cycle ready with read data out.
interface irq_event_src_if;
  logic        i_peri_rden;
  logic        i_peri_wren;
  logic [31:0] i_peri_addr;
  logic [31:0] i_peri_wdata;
  logic [3:0]  i_peri_wstrb;
  logic [31:0] o_peri_rdata;
  logic        o_peri_ready;

  modport master (
    output i_peri_rden, i_peri_wren, i_peri_addr, i_peri_wdata, i_peri_wstrb,
    input  o_peri_rdata, o_peri_ready
  );

  modport slave (
    input  i_peri_rden, i_peri_wren, i_peri_addr, i_peri_wdata, i_peri_wstrb,
    output o_peri_rdata, o_peri_ready
  );
endinterface

// File: rtl/irq_src_coalesce.sv
// Coalescing FSM: waits for enough events or a timeout before raising irq,
// and forces one low cycle after every software service write.
module irq_src_coalesce
  import irq_src_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             pend_any,
  input  logic [CNT_W-1:0] evt_cnt,
  input  logic [7:0]       thresh,
  input  logic [CNT_W-1:0] timeout,
  input  logic             ctl_wr,
  output logic             irq
);

  coal_state_e      state, state_nx;
  logic [CNT_W-1:0] timer;
  logic [7:0]       thresh_eff;
  logic             cnt_hit;
  logic             to_hit;

  assign thresh_eff = (thresh == 8'd0) ? 8'd1 : thresh;
  assign cnt_hit    = 32'(evt_cnt) >= 32'(thresh_eff);
  assign to_hit     = (timeout != '0) && (timer == timeout - CNT_W'(1));

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (pend_any) state_nx = ST_COLLECT;
      ST_COLLECT: begin
        if (!pend_any)             state_nx = ST_IDLE;
        else if (cnt_hit || to_hit) state_nx = ST_FIRE;
      end
      // A service write always forces a low cycle so the controller sees a new edge.
      ST_FIRE: begin
        if (ctl_wr)        state_nx = ST_GAP;
        else if (!pend_any) state_nx = ST_IDLE;
      end
      ST_GAP:     state_nx = pend_any ? ST_COLLECT : ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      timer <= '0;
      irq   <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= (state == ST_COLLECT) ? timer + CNT_W'(1) : '0;
      irq   <= (state_nx == ST_FIRE);
    end
  end

endmodule

// File: rtl/irq_event_src.sv
// Peripheral interrupt source: edge capture into sticky pending bits,
// event counting, register file and bus decode around the coalescing FSM.
module irq_event_src
  import irq_src_pkg::*;
#(
  parameter int NUM_EVT = 8,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_EVT-1:0] i_evt,
  irq_event_src_if.slave     peri,
  output logic               o_irq
);

  logic [NUM_EVT-1:0] evt_p1;
  logic [NUM_EVT-1:0] pending;
  logic [NUM_EVT-1:0] enable;
  logic [NUM_EVT-1:0] rise;
  logic [NUM_EVT-1:0] clr_bits;
  logic [7:0]         thresh;
  logic [CNT_W-1:0]   timeout;
  logic [CNT_W-1:0]   evt_cnt;
  logic [CNT_W-1:0]   evt_cnt_nx;
  logic [2:0]         reg_idx;
  logic               wr_clear;
  logic               wr_enable;
  logic               wr_thresh;
  logic               wr_timeout;
  logic [31:0]        rd_val;
  logic               unused_addr;

  function automatic logic [5:0] popcnt(input logic [NUM_EVT-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < NUM_EVT; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign reg_idx     = peri.i_peri_addr[4:2];
  assign unused_addr = ^{peri.i_peri_addr[31:5], peri.i_peri_addr[1:0]};
  assign wr_clear    = peri.i_peri_wren && (reg_idx == REG_CLEAR);
  assign wr_enable   = peri.i_peri_wren && (reg_idx == REG_ENABLE);
  assign wr_thresh   = peri.i_peri_wren && (reg_idx == REG_THRESH);
  assign wr_timeout  = peri.i_peri_wren && (reg_idx == REG_TIMEOUT);

  assign rise     = i_evt & ~evt_p1;
  assign clr_bits = wr_clear ? NUM_EVT'(peri.i_peri_wdata & strb_mask(peri.i_peri_wstrb))
                             : '0;
  // A CLEAR write restarts the count but still credits edges of the same cycle.
  assign evt_cnt_nx = sat_add(wr_clear ? '0 : evt_cnt, CNT_W'(popcnt(rise & enable)));

  // p1: edge history and register state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      evt_p1  <= '0;
      pending <= '0;
      enable  <= '0;
      thresh  <= THRESH_RST;
      timeout <= CNT_W'(TIMEOUT_RST);
      evt_cnt <= '0;
    end else begin
      evt_p1  <= i_evt;
      pending <= (pending & ~clr_bits) | rise;
      evt_cnt <= evt_cnt_nx;
      if (wr_enable)
        enable <= NUM_EVT'(wstrb_merge(32'(enable), peri.i_peri_wdata, peri.i_peri_wstrb));
      if (wr_thresh && peri.i_peri_wstrb[0])
        thresh <= peri.i_peri_wdata[7:0];
      if (wr_timeout)
        timeout <= CNT_W'(wstrb_merge(32'(timeout), peri.i_peri_wdata, peri.i_peri_wstrb));
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_PENDING: rd_val = 32'(pending);
      REG_ENABLE:  rd_val = 32'(enable);
      REG_THRESH:  rd_val = {24'd0, thresh};
      REG_TIMEOUT: rd_val = 32'(timeout);
      REG_EVT_CNT: rd_val = 32'(evt_cnt);
      REG_RAW:     rd_val = 32'(i_evt);
      default:     rd_val = '0;
    endcase
  end

  // p1: bus response
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      peri.o_peri_ready <= 1'b0;
      peri.o_peri_rdata <= '0;
    end else begin
      peri.o_peri_ready <= peri.i_peri_rden | peri.i_peri_wren;
      peri.o_peri_rdata <= (peri.i_peri_rden && !peri.i_peri_wren) ? rd_val : '0;
    end
  end

  irq_src_coalesce #(.CNT_W(CNT_W)) u_coalesce (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .pend_any (|(pending & enable)),
    .evt_cnt  (evt_cnt),
    .thresh   (thresh),
    .timeout  (timeout),
    .ctl_wr   (wr_clear | wr_enable),
    .irq      (o_irq)
  );

endmodule

// File: tb/tb_irq_event_src.sv
// Self-checking bench for irq_event_src: directed interrupt scenarios plus a
// randomized register-level run against a behavioural model.
module tb_irq_event_src;

  localparam int NUM_EVT = 8;
  localparam int CNT_W   = 16;
  localparam logic [31:0] A_PEND = 32'h00, A_EN = 32'h04, A_CLR = 32'h08, A_THR = 32'h0C;
  localparam logic [31:0] A_TO = 32'h10, A_CNT = 32'h14, A_RAW = 32'h18;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_EVT-1:0] evt = '0;
  logic               irq;
  int                 n_cmp = 0;
  int                 n_err = 0;

  irq_event_src_if bus ();

  irq_event_src #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_evt   (evt),
    .peri    (bus),
    .o_irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.i_peri_rden  = 1'b0;
    bus.i_peri_wren  = 1'b0;
    bus.i_peri_addr  = '0;
    bus.i_peri_wdata = '0;
    bus.i_peri_wstrb = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.i_peri_wren  = 1'b1;
    bus.i_peri_addr  = a;
    bus.i_peri_wdata = d;
    bus.i_peri_wstrb = s;
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic rdy);
    bus.i_peri_rden = 1'b1;
    bus.i_peri_addr = a;
    tick();
    d   = bus.o_peri_rdata;
    rdy = bus.o_peri_ready;
    bus_idle();
  endtask

  task automatic test_reset();
    logic [31:0] addrs [6] = '{A_PEND, A_EN, A_CLR, A_THR, A_TO, A_CNT};
    logic [31:0] exps  [6] = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0};
    logic [31:0] d;
    logic        r;
    bus_idle();
    repeat (3) tick();
    n_cmp++;
    if (irq !== 1'b0 || bus.o_peri_ready !== 1'b0 || bus.o_peri_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: irq=%b ready=%b rdata=%h, want 0/0/0", irq, bus.o_peri_ready, bus.o_peri_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      bus_read(addrs[i], d, r);
      n_cmp++;
      if (d !== exps[i] || r !== 1'b1) begin
        n_err++;
        $display("FAIL reset_reg[%0h]: got %h ready=%b, want %h ready=1", addrs[i], d, r, exps[i]);
      end
    end
    tick();
    n_cmp++;
    if (bus.o_peri_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_pulse: ready=%b, want 0", bus.o_peri_ready);
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic        r;
    bus_write(A_EN, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_EN, d, r);
    n_cmp++;
    if (d !== 32'h0000_00FF) begin n_err++; $display("FAIL enable_width: got %h want 000000ff", d); end
    bus_write(A_EN, 32'h0, 4'h0);
    bus_read(A_EN, d, r);
    n_cmp++;
    if (d !== 32'h0000_00FF) begin n_err++; $display("FAIL enable_nostrb: got %h want 000000ff", d); end
    bus_write(A_EN, 32'h0, 4'h1);
    bus_write(A_THR, 32'hABCD_1234, 4'hF);
    bus_read(A_THR, d, r);
    n_cmp++;
    if (d !== 32'h0000_0034) begin n_err++; $display("FAIL thresh_width: got %h want 00000034", d); end
    bus_write(A_TO, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_TO, d, r);
    n_cmp++;
    if (d !== 32'h0000_FFFF) begin n_err++; $display("FAIL timeout_width: got %h want 0000ffff", d); end
    bus_write(A_TO, 32'h0, 4'hF);
    // simultaneous read and write: write happens, data reads back 0
    bus.i_peri_rden  = 1'b1;
    bus.i_peri_wren  = 1'b1;
    bus.i_peri_addr  = A_THR;
    bus.i_peri_wdata = 32'h5;
    bus.i_peri_wstrb = 4'hF;
    tick();
    n_cmp++;
    if (bus.o_peri_rdata !== 32'h0 || bus.o_peri_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rd_wr_collide: rdata=%h ready=%b, want 0/1", bus.o_peri_rdata, bus.o_peri_ready);
    end
    bus_idle();
    bus_read(A_THR, d, r);
    n_cmp++;
    if (d !== 32'h5) begin n_err++; $display("FAIL collide_write: got %h want 5", d); end
    bus_write(A_THR, 32'h1, 4'hF);
    evt = 8'hA5;
    bus_read(A_RAW, d, r);
    n_cmp++;
    if (d !== 32'h0000_00A5) begin n_err++; $display("FAIL raw_read: got %h want a5", d); end
    evt = '0;
    bus_write(A_CLR, 32'hFF, 4'hF);
    bus_read(A_PEND, d, r);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL clear_all: got %h want 0", d); end
  endtask

  task automatic test_basic_irq();
    logic [31:0] d;
    logic        r;
    bus_write(A_EN, 32'h01, 4'hF);
    tick();
    evt = 8'h01;
    tick();
    evt = '0;
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL basic_t1: irq=%b want 0", irq); end
    bus.i_peri_rden = 1'b1;
    bus.i_peri_addr = A_PEND;
    tick();
    n_cmp++;
    if (bus.o_peri_rdata !== 32'h1 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL basic_t2: pending=%h irq=%b, want 1/0", bus.o_peri_rdata, irq);
    end
    bus_idle();
    tick();
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL basic_t3: irq=%b want 1", irq); end
    bus_write(A_CLR, 32'h01, 4'hF);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL basic_clear: irq=%b want 0", irq); end
    bus_read(A_PEND, d, r);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL basic_pend_clr: got %h want 0", d); end
    tick();
  endtask

  task automatic test_thresh();
    logic [31:0] d;
    logic        r;
    logic        early = 1'b0;
    bus_write(A_CLR, 32'hFF, 4'hF);
    bus_write(A_EN, 32'h04, 4'hF);
    bus_write(A_THR, 32'h03, 4'hF);
    tick();
    for (int k = 0; k < 3; k++) begin
      evt = 8'h04;
      tick();
      evt = '0;
      if (k < 2) begin
        for (int c = 0; c < 4; c++) begin
          if (irq !== 1'b0) early = 1'b1;
          tick();
        end
      end
    end
    n_cmp++;
    if (early || irq !== 1'b0) begin n_err++; $display("FAIL thresh_early: irq=%b early=%b, want 0/0", irq, early); end
    tick();
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL thresh_fire: irq=%b want 1", irq); end
    bus_read(A_CNT, d, r);
    n_cmp++;
    if (d !== 32'h3) begin n_err++; $display("FAIL thresh_cnt: got %h want 3", d); end
    bus_write(A_CLR, 32'hFF, 4'hF);
    bus_write(A_THR, 32'h01, 4'hF);
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bus_write(A_THR, 32'h08, 4'hF);
    bus_write(A_TO, 32'd20, 4'hF);
    bus_write(A_EN, 32'h02, 4'hF);
    bus_write(A_CLR, 32'hFF, 4'hF);
    tick();
    evt = 8'h02;
    tick();
    evt = '0;
    n = 1;
    while (irq === 1'b0 && n < 60) begin
      tick();
      n++;
    end
    // COLLECT is entered two cycles after the edge, then 20 cycles of timer
    n_cmp++;
    if (n !== 22) begin n_err++; $display("FAIL timeout_latency: rose after %0d cycles, want 22", n); end
    bus_write(A_CLR, 32'hFF, 4'hF);
    bus_write(A_TO, 32'h0, 4'hF);
    bus_write(A_THR, 32'h01, 4'hF);
    tick();
  endtask

  task automatic test_set_wins();
    bus_write(A_EN, 32'h01, 4'hF);
    bus_write(A_CLR, 32'hFF, 4'hF);
    tick();
    evt = 8'h01;
    tick();
    evt = '0;
    tick();
    tick();
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL setwins_fire: irq=%b want 1", irq); end
    evt = 8'h01;
    bus.i_peri_wren  = 1'b1;
    bus.i_peri_addr  = A_CLR;
    bus.i_peri_wdata = 32'h01;
    bus.i_peri_wstrb = 4'hF;
    tick();
    evt = '0;
    bus_idle();
    bus.i_peri_rden = 1'b1;
    bus.i_peri_addr = A_PEND;
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL setwins_gap: irq=%b want 0", irq); end
    tick();
    n_cmp++;
    if (bus.o_peri_rdata !== 32'h1 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL setwins_pend: pending=%h irq=%b, want 1/0", bus.o_peri_rdata, irq);
    end
    bus_idle();
    tick();
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL setwins_refire: irq=%b want 1", irq); end
    bus_write(A_CLR, 32'hFF, 4'hF);
    tick();
  endtask

  task automatic test_disabled();
    logic [31:0] d;
    logic        r;
    logic        early = 1'b0;
    int          n;
    bus_write(A_CLR, 32'hFF, 4'hF);
    bus_write(A_EN, 32'h0, 4'hF);
    bus_write(A_TO, 32'd3, 4'hF);
    tick();
    evt = 8'h20;
    tick();
    evt = '0;
    for (int c = 0; c < 6; c++) begin
      if (irq !== 1'b0) early = 1'b1;
      tick();
    end
    n_cmp++;
    if (early) begin n_err++; $display("FAIL disabled_noirq: irq=1 seen, want 0"); end
    bus_read(A_PEND, d, r);
    n_cmp++;
    if (d !== 32'h20) begin n_err++; $display("FAIL disabled_pend: got %h want 20", d); end
    bus_write(A_EN, 32'h20, 4'hF);
    n = 0;
    while (irq === 1'b0 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 4) begin n_err++; $display("FAIL enable_fire: rose after %0d cycles, want 4", n); end
    bus_write(A_EN, 32'h0, 4'hF);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL enable_off: irq=%b want 0", irq); end
    bus_write(A_CLR, 32'hFF, 4'hF);
    bus_write(A_TO, 32'h0, 4'hF);
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        r;
    int          n;
    bus_write(A_THR, 32'h07, 4'hF);
    bus_write(A_TO, 32'h2, 4'hF);
    bus_write(A_EN, 32'h01, 4'hF);
    evt = 8'h01;
    tick();
    evt = '0;
    n = 0;
    while (irq === 1'b0 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL rstmid_fire: irq=%b want 1", irq); end
    bus.i_peri_rden = 1'b1;
    bus.i_peri_addr = A_THR;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (irq !== 1'b0 || bus.o_peri_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async: irq=%b ready=%b, want 0/0", irq, bus.o_peri_ready);
    end
    tick();
    n_cmp++;
    if (bus.o_peri_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_drop: ready=%b want 0", bus.o_peri_ready); end
    bus_idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus_read(A_PEND, d, r);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL rstmid_pend: got %h want 0", d); end
    bus_read(A_EN, d, r);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL rstmid_en: got %h want 0", d); end
    bus_read(A_THR, d, r);
    n_cmp++;
    if (d !== 32'h1) begin n_err++; $display("FAIL rstmid_thr: got %h want 1", d); end
  endtask

  // Reference: pending is sticky OR of rising edges minus W1C bits (edge wins),
  // the counter sums enabled rising edges and restarts on any CLEAR write.
  task automatic test_random();
    logic [NUM_EVT-1:0] m_pend = '0, m_en = '0, m_prev = '0, nevt, rise, clr;
    int                 m_cnt = 0;
    int                 op;
    logic [31:0]        data, expv;
    for (int i = 0; i < 400; i++) begin
      nevt = NUM_EVT'($urandom_range(0, 255));
      op   = $urandom_range(0, 5);
      data = $urandom;
      evt  = nevt;
      expv = '0;
      case (op)
        1: begin bus.i_peri_wren = 1'b1; bus.i_peri_addr = A_EN;  end
        2: begin bus.i_peri_wren = 1'b1; bus.i_peri_addr = A_CLR; end
        3: begin bus.i_peri_rden = 1'b1; bus.i_peri_addr = A_PEND; expv = 32'(m_pend); end
        4: begin bus.i_peri_rden = 1'b1; bus.i_peri_addr = A_CNT;  expv = 32'(m_cnt);  end
        5: begin bus.i_peri_rden = 1'b1; bus.i_peri_addr = A_RAW;  expv = 32'(nevt);   end
        default: ;
      endcase
      bus.i_peri_wdata = data;
      bus.i_peri_wstrb = 4'hF;
      tick();
      if (op != 0) begin
        n_cmp++;
        if (bus.o_peri_rdata !== expv || bus.o_peri_ready !== 1'b1) begin
          n_err++;
          $display("FAIL rand[%0d] op%0d: rdata=%h ready=%b, want %h/1", i, op, bus.o_peri_rdata, bus.o_peri_ready, expv);
        end
      end
      rise  = nevt & ~m_prev;
      clr   = (op == 2) ? data[NUM_EVT-1:0] : '0;
      m_cnt = ((op == 2) ? 0 : m_cnt) + $countones(rise & m_en);
      if (m_cnt > 65535) m_cnt = 65535;
      m_pend = (m_pend & ~clr) | rise;
      if (op == 1) m_en = data[NUM_EVT-1:0];
      m_prev = nevt;
      bus_idle();
    end
    evt = '0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_regs();
    test_basic_irq();
    test_thresh();
    test_timeout();
    test_set_wins();
    test_disabled();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_event_src.md
# irq_event_src

Peripheral-side interrupt source: collects per-event rising edges from a peripheral into sticky pending bits, masks and coalesces them, and drives one level interrupt line into the SoC interrupt controller's `i_irq` bitmap. The controller edge-detects that line and clears only its own latched copy, so this block guarantees a fresh rising edge for every new interrupt episode. Software programs and services it through the peripheral bus.

## Interface
- NUM_EVT, 8, number of event inputs (1..32)
- CNT_W, 16, width of event counter and timeout counter
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_evt  in  NUM_EVT  event levels from the peripheral, synchronous to i_clk
- i_peri_rden  in  1  bus read strobe, one cycle
- i_peri_wren  in  1  bus write strobe, one cycle
- i_peri_addr  in  32  byte address; only [4:2] decoded
- i_peri_wdata  in  32  write data
- i_peri_wstrb  in  4  byte enables
- o_peri_rdata  out  32  read data, valid with o_peri_ready
- o_peri_ready  out  1  one-cycle access completion
- o_irq  out  1  level interrupt to the interrupt controller

## Operation
- Registers (word offset): 0x00 PENDING RO; 0x04 ENABLE RW; 0x08 CLEAR W1C, reads 0; 0x0C THRESH [7:0] RW, value 0 treated as 1; 0x10 TIMEOUT [CNT_W-1:0] RW, 0 disables timeout; 0x14 EVT_CNT RO; 0x18 RAW RO (current i_evt). Bits above NUM_EVT/field width read 0; writes ignored.
- Reset values: o_irq 0, o_peri_ready 0, o_peri_rdata 0, PENDING 0, ENABLE 0, THRESH 1, TIMEOUT 0, EVT_CNT 0, edge history 0.
- Edge detect: registered copy of i_evt; bit rising sets PENDING[k] regardless of ENABLE.
- EVT_CNT adds popcount of rising edges on enabled bits per cycle, saturating at all-ones; zeroed by any CLEAR write.
- Set wins: an edge and a W1C on the same bit in the same cycle leave the bit set.
- FSM states:
  - IDLE: (PENDING & ENABLE)==0. Goes to COLLECT when nonzero; the timer loads 0.
  - COLLECT: the timer increments. Goes to FIRE when EVT_CNT >= THRESH, or TIMEOUT!=0 and timer==TIMEOUT-1. Goes to IDLE if the masked pending becomes zero.
  - FIRE: o_irq=1. Goes to GAP on any CLEAR write or ENABLE write; goes to IDLE if the masked pending becomes zero.
  - GAP: o_irq=0 for exactly one cycle. Then goes to COLLECT if the masked pending is nonzero, else IDLE.
- GAP guarantees a low cycle, so a post-clear residual or new event produces a new rising edge at the controller.
- Reset mid-operation: all state returns immediately to the reset values; outstanding bus access is dropped (no ready).

## Timing
- Event edge at cycle t (i_evt low at t-1, high at t): PENDING set visible at t+1. With THRESH=1, FSM leaves IDLE at t+1 and o_irq=1 at t+3 (IDLE→COLLECT→FIRE, o_irq registered).
- Bus: strobe at cycle t, o_peri_ready=1 and rdata valid at t+1, for one cycle; write side effects visible at t+1. Simultaneous rden and wren: write performed, rdata 0.
- o_irq is a registered output, glitch-free.

## Structure
- Shared package irq_src_pkg: register offset constants, FSM state enum (IDLE/COLLECT/FIRE/GAP), THRESH/TIMEOUT reset constants.
- Sub-module irq_src_coalesce: holds the FSM and the timeout counter. Inputs: masked-pending-nonzero, EVT_CNT, THRESH, TIMEOUT, clear/enable-write pulse. Output: o_irq. Edge detect, registers and bus decode stay in the top.

## Test plan
- ENABLE=0x01, THRESH=1, pulse i_evt[0] → PENDING=0x01 next cycle, o_irq high 3 cycles after edge; write CLEAR=0x01 → o_irq low, PENDING=0.
- THRESH=3, TIMEOUT=0, three edges on bit 2 spaced 5 cycles → o_irq stays low until third edge accepted, EVT_CNT=3.
- THRESH=8, TIMEOUT=20, single edge → o_irq rises 20 cycles after COLLECT entry.
- In FIRE, CLEAR=0x01 on the same cycle as a new edge on bit 0 → PENDING[0] stays 1, o_irq low exactly one cycle, then high again.
- Edge on disabled bit 5 → PENDING[5]=1, no irq; then write ENABLE=0x20 → o_irq rises; write ENABLE=0 → o_irq falls.
- Assert i_rst_n low while o_irq=1 → o_irq, PENDING and ENABLE zero immediately; THRESH reads 1.
